// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI transfer control path.
// Latency: n/a (types, constants and elaboration helpers only).
// Backpressure: n/a.
//
// Contents:
//   SPI_WORD_W   width of a buffer word {ss[1:0], tx[31:0]}
//   seq_state_t  transfer sequencer state encoding
//   timer_width  counter width needed to count 0 .. limit-1
package spi_ctrl_pkg;

  localparam int unsigned SPI_WORD_W = 34;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    GO,
    WAIT_RDY,
    LAUNCH,
    SHIFT,
    GAP,
    ERROR
  } seq_state_t;

  // A counter that must reach limit-1 needs clog2(limit) bits; keep at
  // least one bit so a limit of 1 or 2 still elaborates to a real register.
  function automatic int unsigned timer_width(input int unsigned limit);
    return (limit > 2) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/spi_cycle_timer.sv
// Load/count/expire cycle timer used for the DREADY timeout and the inter-transfer gap.
// Latency: expired rises LIMIT-1 enabled counts after load.
// Backpressure: none; the counter saturates at LIMIT-1 and holds until reloaded.
//
// Ports:
//   SCLK      in   clock
//   ARESETN   in   synchronous, active-low reset (count -> 0)
//   load      in   restart the count from 0 (wins over count_en)
//   count_en  in   advance the count by one this cycle
//   expired   out  count has reached LIMIT-1
module spi_cycle_timer
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = 2
) (
  input  logic SCLK,
  input  logic ARESETN,
  input  logic load,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned W = timer_width(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  // Saturating at LAST means a caller may sit in a state with the timer
  // enabled for as long as it likes without the count wrapping back to 0.
  always_ff @(posedge SCLK) begin
    if (!ARESETN) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (count_en && (count != LAST)) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Schedules transfers: pops TX+SS together, requests the buffer word, launches the shift engine.
// Latency: IDLE->go 2 cycles; dready->shift_start 1 cycle; period >= 5 + GAP_CYCLES + shift time.
// Backpressure: waits on empty FIFOs, dready (with timeout) and shift_done; enable gates new starts.
//
// Ports:
//   SCLK, ARESETN          clock, synchronous active-low reset
//   enable                 allow a new transfer to start from IDLE
//   clr_err                leave ERROR and clear timeout_err
//   tx_empty, ss_empty     FIFO status; both must be non-empty to start
//   tx_rd_en, ss_rd_en     one-cycle pop strobes, always issued together
//   go                     one-cycle request to the data buffer
//   dready, dword          data buffer word valid / word
//   sresp                  one-cycle ack to the data buffer
//   shift_start            one-cycle launch to the shift engine
//   shift_word             captured word presented to the shift engine
//   shift_done             one-cycle completion pulse from the shift engine
//   busy                   sequencer not in IDLE
//   timeout_err            sticky DREADY timeout flag
//   xfer_count             completed transfers, wrapping
module spi_xfer_sequencer
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W         = SPI_WORD_W,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic              SCLK,
  input  logic              ARESETN,
  input  logic              enable,
  input  logic              clr_err,
  input  logic              tx_empty,
  input  logic              ss_empty,
  output logic              tx_rd_en,
  output logic              ss_rd_en,
  output logic              go,
  input  logic              dready,
  input  logic [DATA_W-1:0] dword,
  output logic              sresp,
  output logic              shift_start,
  output logic [DATA_W-1:0] shift_word,
  input  logic              shift_done,
  output logic              busy,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  xfer_count
);

  seq_state_t state;
  seq_state_t next_state;

  logic to_load;
  logic to_count;
  logic to_expired;
  logic gap_load;
  logic gap_count;
  logic gap_expired;

  // The timeout timer restarts in GO so every WAIT_RDY visit gets the full
  // TIMEOUT_CYCLES budget; it only advances while the buffer is not ready.
  assign to_load  = (state == GO);
  assign to_count = (state == WAIT_RDY) && !dready;

  // The gap timer is held at zero throughout SHIFT, so it is already clear
  // on the first GAP cycle no matter how long the shift took.
  assign gap_load  = (state == SHIFT);
  assign gap_count = (state == GAP);

  spi_cycle_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_timer (
    .SCLK     (SCLK),
    .ARESETN  (ARESETN),
    .load     (to_load),
    .count_en (to_count),
    .expired  (to_expired)
  );

  spi_cycle_timer #(
    .LIMIT (GAP_CYCLES)
  ) u_gap_timer (
    .SCLK     (SCLK),
    .ARESETN  (ARESETN),
    .load     (gap_load),
    .count_en (gap_count),
    .expired  (gap_expired)
  );

  always_ff @(posedge SCLK) begin
    if (!ARESETN) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Moore machine: every strobe is a pure decode of the current state, so
  // each is exactly one cycle wide and reset drops them all at once.
  always_comb begin
    next_state  = state;
    tx_rd_en    = 1'b0;
    ss_rd_en    = 1'b0;
    go          = 1'b0;
    sresp       = 1'b0;
    shift_start = 1'b0;
    busy        = 1'b1;
    timeout_err = 1'b0;

    case (state)
      IDLE: begin
        busy = 1'b0;
        // Both FIFOs must hold a word; popping only one would desync TX/SS.
        if (enable && !tx_empty && !ss_empty) begin
          next_state = POP;
        end
      end

      POP: begin
        tx_rd_en   = 1'b1;
        ss_rd_en   = 1'b1;
        next_state = GO;
      end

      GO: begin
        go         = 1'b1;
        next_state = WAIT_RDY;
      end

      WAIT_RDY: begin
        if (dready) begin
          next_state = LAUNCH;
        end else if (to_expired) begin
          next_state = ERROR;
        end
      end

      LAUNCH: begin
        shift_start = 1'b1;
        sresp       = 1'b1;
        next_state  = SHIFT;
      end

      SHIFT: begin
        if (shift_done) begin
          next_state = GAP;
        end
      end

      GAP: begin
        // The buffer may keep dready high for a couple of cycles after
        // sresp; waiting for it to drop keeps the next WAIT_RDY from
        // capturing the word we just consumed.
        if (gap_expired && !dready) begin
          next_state = IDLE;
        end
      end

      ERROR: begin
        timeout_err = 1'b1;
        if (clr_err) begin
          next_state = IDLE;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Capture happens on the WAIT_RDY->LAUNCH edge so shift_word is already
  // stable in the cycle shift_start is raised.
  always_ff @(posedge SCLK) begin
    if (!ARESETN) begin
      shift_word <= '0;
    end else if ((state == WAIT_RDY) && dready) begin
      shift_word <= dword;
    end
  end

  always_ff @(posedge SCLK) begin
    if (!ARESETN) begin
      xfer_count <= '0;
    end else if ((state == SHIFT) && shift_done) begin
      xfer_count <= xfer_count + CNT_W'(1);
    end
  end

endmodule
